fsm_input_enable_param: RTL and testbench
=========================================

// Module: fsm_input_enable_param
// PURPOSE
//  Parametrised operand-input controller for the FPU add/sub pipeline front end.
//  - On an operation request, opens an input-accept window of IN_CYCLES cycles.
//  - Keeps the shift-register enable high for SHIFT_CYCLES cycles in total.
//  - Adds back-to-back restart, a one-deep pending request, stall, flush, busy and op_done.
//  - Sits between the FPU interface request logic and the first pipeline stage / shift registers.
// PARAMETERS
//  IN_CYCLES     3  cycles with input+shift enabled (LOAD phase); 1 <= IN_CYCLES <= SHIFT_CYCLES
//  SHIFT_CYCLES  6  total shift-enabled cycles per operation (LOAD + DRAIN); <= 2**CNT_W
//  CNT_W         4  width of the internal phase counter
// PORTS
//  clk                    in   1  clock; all state changes on the rising edge
//  rst                    in   1  asynchronous, active-low reset (0 = reset)
//  init_OPERATION         in   1  operation request, level; sampled every cycle
//  stall                  in   1  freeze sequence (downstream not ready)
//  flush                  in   1  synchronous abort of the current operation
//  enable_input_internal  out  1  Moore input-window enable
//  enable_Pipeline_input  out  1  enable_input_internal & init_OPERATION (combinational)
//  enable_shift_reg       out  1  Moore shift-register enable
//  busy                   out  1  1 whenever state != IDLE
//  op_done                out  1  registered, one-cycle completion pulse
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cnt=0, pending=0, op_done=0.
//   Outputs while in reset: enable_shift_reg=0, busy=0, enable_input_internal=1 (IDLE value, stall=0).
//  States: IDLE, LOAD, DRAIN. cnt counts 0..SHIFT_CYCLES-1 across LOAD+DRAIN.
//  IDLE:
//   - Outputs: input=!stall, shift=0.
//   - init=1 & !stall & !flush -> LOAD next cycle, cnt=0.
//  LOAD:
//   - Outputs: input=1, shift=1. cnt increments each cycle.
//   - At cnt=IN_CYCLES-1: -> DRAIN, or the last-cycle rule applies if IN_CYCLES=SHIFT_CYCLES.
//  DRAIN:
//   - Outputs: input=0, shift=1. cnt increments each cycle.
//   - init=1 in any DRAIN cycle sets pending.
//  Last cycle (cnt=SHIFT_CYCLES-1):
//   - op_done=1 in the next cycle.
//   - init|pending -> LOAD with cnt=0 and pending cleared; there is no IDLE gap.
//   - Otherwise -> IDLE.
//  Stall (stall=1, no flush):
//   - state, cnt and pending hold; input=0, shift=0; busy unchanged.
//   - The op_done pulse is postponed with the sequence.
//  Flush (priority over stall and init):
//   - Outputs 0 during the flush cycle; next state IDLE, cnt=0, pending=0.
//   - No op_done is issued for the aborted operation.
//  Simultaneous events:
//   - init in the last cycle together with an already set pending: a single restart; pending is cleared.
//   - init during LOAD is ignored; it is not queued.
//  Latency: request in IDLE -> first LOAD cycle +1; op_done at +SHIFT_CYCLES+1 after the request cycle.
//  Reset mid-operation: immediate return to IDLE values; no op_done.
// TESTING (defaults IN=3, SHIFT=6; c0 = request cycle)
//  1 init=1 at c0 only -> enable_Pipeline_input=1 at c0; input+shift=1 c1-c3; shift only c4-c6;
//    op_done=1 at c7; busy=1 c1-c6.
//  2 init held high -> LOAD restarts at c7 with no IDLE gap; op_done at c7, c13, c19 ...
//  3 init pulse at c5 only -> pending set; LOAD restarts at c7; second op_done at c13.
//  4 stall=1 at c2-c3 -> input=shift=0 at c2-c3, busy=1; LOAD resumes at c4; op_done at c9.
//  5 flush at c4, init pulse at c3 -> IDLE at c5, busy=0, no op_done, no restart.
//  6 rst=0 at c5 -> shift=0 and busy=0 immediately; after release, init restarts normally.
//    Repeat scenarios 1-2 with IN=SHIFT=1.

Source files
------------

// File: rtl/fsm_input_enable_param.sv
// Operand-input controller for the FPU add/sub front end: opens a LOAD window, drains the
// shift registers, and supports back-to-back restart, a one-deep pending request, stall and flush.
module fsm_input_enable_param #(
  parameter int IN_CYCLES    = 3,
  parameter int SHIFT_CYCLES = 6,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic init_OPERATION,
  input  logic stall,
  input  logic flush,
  output logic enable_input_internal,
  output logic enable_Pipeline_input,
  output logic enable_shift_reg,
  output logic busy,
  output logic op_done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  localparam logic [CNT_W-1:0] IN_LAST    = CNT_W'(IN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pending, w_pending_nxt;
  logic             r_op_done, w_done_nxt;
  logic             w_en_in, w_en_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_op_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_op_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_done_nxt    = 1'b0;
    w_en_in       = 1'b0;
    w_en_shift    = 1'b0;
    if (flush) begin
      // Abort: no op_done for the discarded operation
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_pending_nxt = 1'b0;
    end else if (!stall) begin
      case (r_state)
        IDLE: begin
          w_en_in = 1'b1;
          if (init_OPERATION) begin
            w_state_nxt = LOAD;
            w_cnt_nxt   = '0;
          end
        end
        LOAD: begin
          w_en_in    = 1'b1;
          w_en_shift = 1'b1;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
          if (r_cnt == IN_LAST) w_state_nxt = DRAIN;
        end
        DRAIN: begin
          w_en_shift = 1'b1;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
          if (init_OPERATION) w_pending_nxt = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
      // Last shift cycle overrides the above; a new or queued request restarts without an IDLE gap
      if (r_state != IDLE && r_cnt == SHIFT_LAST) begin
        w_done_nxt    = 1'b1;
        w_cnt_nxt     = '0;
        w_pending_nxt = 1'b0;
        w_state_nxt   = (init_OPERATION || r_pending) ? LOAD : IDLE;
      end
    end
  end

  assign enable_input_internal = w_en_in;
  assign enable_Pipeline_input = w_en_in & init_OPERATION;
  assign enable_shift_reg      = w_en_shift;
  assign busy                  = (r_state != IDLE);
  assign op_done               = r_op_done;

endmodule

// File: tb/tb_fsm_input_enable_param.sv
// Directed bench for fsm_input_enable_param: default (IN=3, SHIFT=6) and IN=SHIFT=1 instances.
module tb_fsm_input_enable_param;

  logic clk = 1'b0;
  logic rst;
  logic a_init, a_stall, a_flush;
  logic a_in, a_pipe, a_shift, a_busy, a_done;
  logic b_init, b_stall, b_flush;
  logic b_in, b_pipe, b_shift, b_busy, b_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fsm_input_enable_param #(.IN_CYCLES(3), .SHIFT_CYCLES(6), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .init_OPERATION(a_init), .stall(a_stall), .flush(a_flush),
    .enable_input_internal(a_in), .enable_Pipeline_input(a_pipe),
    .enable_shift_reg(a_shift), .busy(a_busy), .op_done(a_done)
  );

  fsm_input_enable_param #(.IN_CYCLES(1), .SHIFT_CYCLES(1), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .init_OPERATION(b_init), .stall(b_stall), .flush(b_flush),
    .enable_input_internal(b_in), .enable_Pipeline_input(b_pipe),
    .enable_shift_reg(b_shift), .busy(b_busy), .op_done(b_done)
  );

  // Observed/expected vectors are {input, pipeline_input, shift, busy, op_done}
  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One clock cycle on the selected instance: drive inputs, sample mid-cycle, advance
  task automatic cyc(input bit sel_b, input logic init, input logic stl, input logic fl,
                     input logic [4:0] exp, input string tag);
    a_init = 1'b0; a_stall = 1'b0; a_flush = 1'b0;
    b_init = 1'b0; b_stall = 1'b0; b_flush = 1'b0;
    if (sel_b) begin
      b_init = init; b_stall = stl; b_flush = fl;
    end else begin
      a_init = init; a_stall = stl; a_flush = fl;
    end
    #4;
    if (sel_b) chk(tag, {b_in, b_pipe, b_shift, b_busy, b_done}, exp);
    else       chk(tag, {a_in, a_pipe, a_shift, a_busy, a_done}, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_init = 1'b0; a_stall = 1'b0; a_flush = 1'b0;
    b_init = 1'b0; b_stall = 1'b0; b_flush = 1'b0;
    #3;
    chk("reset_a", {a_in, a_pipe, a_shift, a_busy, a_done}, 5'b10000);
    chk("reset_b", {b_in, b_pipe, b_shift, b_busy, b_done}, 5'b10000);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 5'b10000, "idle");

    // Single request
    cyc(0, 1, 0, 0, 5'b11000, "s1_c0");
    for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 0, 5'b10110, $sformatf("s1_load_c%0d", i));
    for (int i = 4; i <= 6; i++) cyc(0, 0, 0, 0, 5'b00110, $sformatf("s1_drain_c%0d", i));
    cyc(0, 0, 0, 0, 5'b10001, "s1_done_c7");
    cyc(0, 0, 0, 0, 5'b10000, "s1_c8");

    // Request held high: three back-to-back operations, then release
    cyc(0, 1, 0, 0, 5'b11000, "s2_c0");
    for (int op = 0; op < 3; op++) begin
      for (int i = 0; i < 3; i++)
        cyc(0, 1, 0, 0, (op > 0 && i == 0) ? 5'b11111 : 5'b11110, $sformatf("s2_op%0d_load%0d", op, i));
      for (int i = 0; i < 3; i++)
        cyc(0, 1, 0, 0, 5'b00110, $sformatf("s2_op%0d_drain%0d", op, i));
    end
    cyc(0, 0, 0, 0, 5'b10111, "s2_c19_done_restart");
    cyc(0, 0, 0, 0, 5'b10110, "s2_c20");
    cyc(0, 0, 0, 0, 5'b10110, "s2_c21");
    for (int i = 22; i <= 24; i++) cyc(0, 0, 0, 0, 5'b00110, $sformatf("s2_drain_c%0d", i));
    cyc(0, 0, 0, 0, 5'b10001, "s2_done_c25");
    cyc(0, 0, 0, 0, 5'b10000, "s2_c26");

    // Pending request captured in DRAIN
    cyc(0, 1, 0, 0, 5'b11000, "s3_c0");
    for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 0, 5'b10110, $sformatf("s3_load_c%0d", i));
    cyc(0, 0, 0, 0, 5'b00110, "s3_c4");
    cyc(0, 1, 0, 0, 5'b00110, "s3_c5_pend");
    cyc(0, 0, 0, 0, 5'b00110, "s3_c6");
    cyc(0, 0, 0, 0, 5'b10111, "s3_c7_done_restart");
    cyc(0, 0, 0, 0, 5'b10110, "s3_c8");
    cyc(0, 0, 0, 0, 5'b10110, "s3_c9");
    for (int i = 10; i <= 12; i++) cyc(0, 0, 0, 0, 5'b00110, $sformatf("s3_drain_c%0d", i));
    cyc(0, 0, 0, 0, 5'b10001, "s3_done_c13");
    cyc(0, 0, 0, 0, 5'b10000, "s3_c14");

    // Stall during LOAD
    cyc(0, 1, 0, 0, 5'b11000, "s4_c0");
    cyc(0, 0, 0, 0, 5'b10110, "s4_c1");
    cyc(0, 0, 1, 0, 5'b00010, "s4_c2_stall");
    cyc(0, 0, 1, 0, 5'b00010, "s4_c3_stall");
    cyc(0, 0, 0, 0, 5'b10110, "s4_c4");
    cyc(0, 0, 0, 0, 5'b10110, "s4_c5");
    for (int i = 6; i <= 8; i++) cyc(0, 0, 0, 0, 5'b00110, $sformatf("s4_drain_c%0d", i));
    cyc(0, 0, 0, 0, 5'b10001, "s4_done_c9");
    cyc(0, 0, 0, 0, 5'b10000, "s4_c10");

    // Stall on the last cycle postpones op_done; init during stall is not queued
    cyc(0, 1, 0, 0, 5'b11000, "s4b_c0");
    for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 0, 5'b10110, $sformatf("s4b_load_c%0d", i));
    cyc(0, 0, 0, 0, 5'b00110, "s4b_c4");
    cyc(0, 0, 0, 0, 5'b00110, "s4b_c5");
    cyc(0, 1, 1, 0, 5'b00010, "s4b_c6_stall");
    cyc(0, 0, 0, 0, 5'b00110, "s4b_c7_last");
    cyc(0, 0, 0, 0, 5'b10001, "s4b_done_c8");
    cyc(0, 0, 0, 0, 5'b10000, "s4b_c9");

    // Flush in DRAIN with an ignored init in LOAD
    cyc(0, 1, 0, 0, 5'b11000, "s5_c0");
    cyc(0, 0, 0, 0, 5'b10110, "s5_c1");
    cyc(0, 0, 0, 0, 5'b10110, "s5_c2");
    cyc(0, 1, 0, 0, 5'b11110, "s5_c3_init_load");
    cyc(0, 1, 0, 1, 5'b00010, "s5_c4_flush");
    cyc(0, 0, 0, 0, 5'b10000, "s5_c5_idle");
    cyc(0, 0, 0, 0, 5'b10000, "s5_c6_no_done");

    // Idle boundaries: stall or flush blocks a request
    cyc(0, 1, 1, 0, 5'b00000, "idle_stall_init");
    cyc(0, 1, 0, 1, 5'b00000, "idle_flush_init");
    cyc(0, 0, 0, 0, 5'b10000, "idle_after_block");

    // Asynchronous reset mid-operation
    cyc(0, 1, 0, 0, 5'b11000, "s6_c0");
    for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 0, 5'b10110, $sformatf("s6_load_c%0d", i));
    cyc(0, 0, 0, 0, 5'b00110, "s6_c4");
    rst = 1'b0;
    cyc(0, 0, 0, 0, 5'b10000, "s6_c5_rst");
    cyc(0, 0, 0, 0, 5'b10000, "s6_c6_rst");
    rst = 1'b1;
    cyc(0, 0, 0, 0, 5'b10000, "s6_c7_no_done");
    cyc(0, 1, 0, 0, 5'b11000, "s6_re_c0");
    for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 0, 5'b10110, $sformatf("s6_re_load_c%0d", i));
    for (int i = 4; i <= 6; i++) cyc(0, 0, 0, 0, 5'b00110, $sformatf("s6_re_drain_c%0d", i));
    cyc(0, 0, 0, 0, 5'b10001, "s6_re_done_c7");

    // IN=SHIFT=1: single request
    cyc(1, 1, 0, 0, 5'b11000, "b1_c0");
    cyc(1, 0, 0, 0, 5'b10110, "b1_c1_load_last");
    cyc(1, 0, 0, 0, 5'b10001, "b1_c2_done");
    cyc(1, 0, 0, 0, 5'b10000, "b1_c3");

    // IN=SHIFT=1: request held, op_done every cycle
    cyc(1, 1, 0, 0, 5'b11000, "b2_c0");
    cyc(1, 1, 0, 0, 5'b11110, "b2_c1");
    for (int i = 2; i <= 4; i++) cyc(1, 1, 0, 0, 5'b11111, $sformatf("b2_c%0d", i));
    cyc(1, 0, 0, 0, 5'b10111, "b2_c5_release");
    cyc(1, 0, 0, 0, 5'b10001, "b2_c6_done");
    cyc(1, 0, 0, 0, 5'b10000, "b2_c7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
